// File: rtl/nibble_add_arbiter.sv
// NibbleAddArbiter: two requesters share one W-bit adder. A round-robin
// arbiter grants one requester, whose operands are captured and summed with
// full carry. Every transaction walks IDLE -> CAPT -> EXEC -> DONE, so the
// latency is fixed and back-to-back throughput is one sum per four cycles.
module nibble_add_arbiter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         done,
   output logic         owner,
   output logic [W:0]   result,
   output logic         busy,
   output logic [7:0]   txn_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CAPT = 2'd1,
      EXEC = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t       r_state;
   logic         r_gnt0;
   logic         r_gnt1;
   logic         r_done;
   logic         r_owner;
   logic         r_busy;
   logic         r_rrLast;
   logic [W:0]   r_result;
   logic [7:0]   r_txnCnt;
   logic [W-1:0] r_opA;
   logic [W-1:0] r_opB;

   logic         w_anyReq;
   logic         w_grantSel;
   logic [W:0]   w_sum;

   // Pick the next owner: on a tie, the requester that was not served last
   // wins; otherwise whichever single requester is asking.
   always_comb begin
      w_anyReq   = req0 | req1;
      w_grantSel = 1'b0;
      if (req0 && req1) begin
         w_grantSel = ~r_rrLast;
      end else if (req1) begin
         w_grantSel = 1'b1;
      end
      w_sum = {1'b0, r_opA} + {1'b0, r_opB};
   end

   // Transaction FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_gnt0   <= 1'b0;
         r_gnt1   <= 1'b0;
         r_done   <= 1'b0;
         r_owner  <= 1'b0;
         r_busy   <= 1'b0;
         r_rrLast <= 1'b1;
         r_result <= '0;
         r_txnCnt <= 8'd0;
         r_opA    <= '0;
         r_opB    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (ena && w_anyReq) begin
                  r_state <= CAPT;
                  r_owner <= w_grantSel;
                  r_gnt0  <= ~w_grantSel;
                  r_gnt1  <= w_grantSel;
                  r_busy  <= 1'b1;
               end
            end
            CAPT: begin
               r_opA   <= r_owner ? a1 : a0;
               r_opB   <= r_owner ? b1 : b0;
               r_state <= EXEC;
            end
            EXEC: begin
               r_result <= w_sum;
               r_done   <= 1'b1;
               r_rrLast <= r_owner;
               r_state  <= DONE;
            end
            DONE: begin
               r_done   <= 1'b0;
               r_gnt0   <= 1'b0;
               r_gnt1   <= 1'b0;
               r_busy   <= 1'b0;
               r_txnCnt <= r_txnCnt + 8'd1;
               r_state  <= IDLE;
            end
            default: begin
               r_state <= IDLE;
               r_gnt0  <= 1'b0;
               r_gnt1  <= 1'b0;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt0    = r_gnt0;
   assign gnt1    = r_gnt1;
   assign done    = r_done;
   assign owner   = r_owner;
   assign result  = r_result;
   assign busy    = r_busy;
   assign txn_cnt = r_txnCnt;

endmodule

// File: tb/tb_nibble_add_arbiter.sv
// Testbench for nibble_add_arbiter: directed vectors with hand-computed sums,
// stepping one clock at a time and sampling 1 ns after each rising edge.
module tb_nibble_add_arbiter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ena = 1'b0;
   logic         req0 = 1'b0;
   logic         req1 = 1'b0;
   logic [W-1:0] a0 = '0;
   logic [W-1:0] b0 = '0;
   logic [W-1:0] a1 = '0;
   logic [W-1:0] b1 = '0;
   logic         gnt0;
   logic         gnt1;
   logic         done;
   logic         owner;
   logic [W:0]   result;
   logic         busy;
   logic [7:0]   txn_cnt;

   int numChecks = 0;
   int numPassed = 0;
   logic bothGntSeen = 1'b0;
   logic strayDoneSeen = 1'b0;

   nibble_add_arbiter #(.W(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .req0    (req0),
      .req1    (req1),
      .a0      (a0),
      .b0      (b0),
      .a1      (a1),
      .b1      (b1),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .done    (done),
      .owner   (owner),
      .result  (result),
      .busy    (busy),
      .txn_cnt (txn_cnt)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Watch for overlapping grants or a done pulse while the FSM claims to be idle.
   always @(negedge clk) begin
      if (gnt0 && gnt1) bothGntSeen = 1'b1;
      if (done && !busy) strayDoneSeen = 1'b1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numChecks++;
      if (observed === expected) begin
         numPassed++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic r0, input logic r1,
                                input logic [W-1:0] x0, input logic [W-1:0] y0,
                                input logic [W-1:0] x1, input logic [W-1:0] y1);
      ena  = e;
      req0 = r0;
      req1 = r1;
      a0   = x0;
      b0   = y0;
      a1   = x1;
      b1   = y1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, ".gnt0"}, 32'(gnt0), 32'd0);
      checkOutput({tag, ".gnt1"}, 32'(gnt1), 32'd0);
      checkOutput({tag, ".done"}, 32'(done), 32'd0);
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
      checkOutput({tag, ".owner"}, 32'(owner), 32'd0);
      checkOutput({tag, ".result"}, 32'(result), 32'd0);
      checkOutput({tag, ".txn"}, 32'(txn_cnt), 32'd0);
   endtask

   initial begin
      logic expOwner;
      logic [W:0] expSum;

      // Reset state
      tick();
      tick();
      checkIdleOutputs("reset");

      // Single request with carry out: F + F = 1E
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0);
      tick();
      checkOutput("single.gnt0", 32'(gnt0), 32'd1);
      checkOutput("single.gnt1", 32'(gnt1), 32'd0);
      checkOutput("single.busy", 32'(busy), 32'd1);
      checkOutput("single.doneEarly", 32'(done), 32'd0);
      tick();
      checkOutput("single.doneCapt", 32'(done), 32'd0);
      tick();
      checkOutput("single.done", 32'(done), 32'd1);
      checkOutput("single.result", 32'(result), 32'h1E);
      req0 = 1'b0;
      tick();
      checkOutput("single.doneOff", 32'(done), 32'd0);
      checkOutput("single.gntOff", 32'(gnt0), 32'd0);
      checkOutput("single.txn", 32'(txn_cnt), 32'd1);
      tick();
      checkOutput("single.noRegrant", 32'(busy), 32'd0);
      checkOutput("single.holdResult", 32'(result), 32'h1E);

      // Tie from reset: grants alternate 0,1,0,1 every 4 cycles
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 4'h3, 4'h5, 4'h9, 4'hA);
      for (int t = 0; t < 4; t++) begin
         expOwner = t[0];
         expSum = expOwner ? 5'h13 : 5'h08;
         tick();
         checkOutput("tie.owner", 32'(owner), 32'(expOwner));
         checkOutput("tie.gnt0", 32'(gnt0), 32'(!expOwner));
         checkOutput("tie.gnt1", 32'(gnt1), 32'(expOwner));
         tick();
         tick();
         checkOutput("tie.done", 32'(done), 32'd1);
         checkOutput("tie.result", 32'(result), 32'(expSum));
         tick();
         checkOutput("tie.txn", 32'(txn_cnt), 32'(t + 1));
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h3, 4'h5, 4'h9, 4'hA);

      // Enable low blocks new grants; raising it grants on the next edge
      applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h7, 4'h6);
      for (int t = 0; t < 3; t++) begin
         tick();
         checkOutput("ena0.gnt1", 32'(gnt1), 32'd0);
         checkOutput("ena0.busy", 32'(busy), 32'd0);
      end
      ena = 1'b1;
      tick();
      checkOutput("ena1.gnt1", 32'(gnt1), 32'd1);
      checkOutput("ena1.owner", 32'(owner), 32'd1);
      tick();
      tick();
      checkOutput("ena1.done", 32'(done), 32'd1);
      checkOutput("ena1.result", 32'(result), 32'h0D);
      req1 = 1'b0;
      tick();
      checkOutput("ena1.txn", 32'(txn_cnt), 32'd5);

      // Request and operand change during EXEC do not disturb the transaction
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h2, 4'h3, 4'h0, 4'h0);
      tick();
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'hF, 4'h3, 4'h0, 4'h0);
      tick();
      checkOutput("flight.done", 32'(done), 32'd1);
      checkOutput("flight.result", 32'(result), 32'h05);
      tick();
      checkOutput("flight.txn", 32'(txn_cnt), 32'd6);
      checkOutput("flight.idle", 32'(busy), 32'd0);

      // Asynchronous reset during EXEC aborts the transaction
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checkIdleOutputs("asyncRst");
      tick();
      checkOutput("asyncRst.noDone", 32'(done), 32'd0);
      checkOutput("asyncRst.txn", 32'(txn_cnt), 32'd0);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 4'h4, 4'h4, 4'h2, 4'h2);
      tick();
      checkOutput("postRst.gnt0", 32'(gnt0), 32'd1);
      checkOutput("postRst.owner", 32'(owner), 32'd0);
      tick();
      tick();
      checkOutput("postRst.result", 32'(result), 32'h08);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h4, 4'h4, 4'h2, 4'h2);
      tick();
      checkOutput("postRst.txn", 32'(txn_cnt), 32'd1);

      // Counter wrap: 255 more transactions bring the count from 1 through 255 to 0
      applyStimulus(1'b1, 1'b1, 1'b0, 4'h8, 4'h8, 4'h0, 4'h0);
      repeat (254 * 4) tick();
      checkOutput("wrap.txn255", 32'(txn_cnt), 32'd255);
      repeat (4) tick();
      req0 = 1'b0;
      checkOutput("wrap.txn0", 32'(txn_cnt), 32'd0);
      checkOutput("wrap.result", 32'(result), 32'h10);
      tick();
      checkOutput("wrap.idle", 32'(busy), 32'd0);

      checkOutput("never.bothGnt", 32'(bothGntSeen), 32'd0);
      checkOutput("never.strayDone", 32'(strayDoneSeen), 32'd0);

      $display("%0d/%0d checks passed", numPassed, numChecks);
      $finish;
   end

endmodule
